// File: rtl/mul_chain_pipe.sv
// ----------------------------------------------------------------------------
// mul_chain_pipe
//
// Fully pipelined unsigned multiply chain:
//   y = op[0] * op[1] * ... * op[NUM_OPS-1]
// There is one multiply per stage (NUM_OPS-1 stages), followed by an output
// register that applies the truncate/saturate selection. Latency is NUM_OPS
// cycles when nothing stalls. One result per cycle while out_ready is high.
//
// The whole pipeline moves on a single global advance:
//   adv = !out_valid || out_ready
// so every stage either shifts one place or holds. Bubbles are not collapsed.
//
// Parameters
//   NUM_OPS  number of chained operands (>= 2)
//   OP_W     operand width
//   OUT_W    partial product / result width (>= OP_W)
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    operand bundle valid
//   in_ready    bundle can be accepted this cycle (equals adv)
//   in_ops      packed operands, op[k] = in_ops[k*OP_W +: OP_W]
//   in_sat      per-transaction mode: 0 = truncate, 1 = saturate
//   out_valid   result valid
//   out_ready   downstream accepts the result
//   out_data    result (all-ones when saturating an overflowed product)
//   out_ovf     some discarded product bit along the chain was nonzero
//
// Optional build macro
//   MUL_CHAIN_STATS_EN  adds stat_xfers / stat_ovf (16-bit saturating
//                       counters of retired results and retired overflows)
// ----------------------------------------------------------------------------
module mul_chain_pipe #(
    parameter int unsigned NUM_OPS = 3,
    parameter int unsigned OP_W    = 16,
    parameter int unsigned OUT_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_OPS*OP_W-1:0] in_ops,
    input  logic                    in_sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_ovf
`ifdef MUL_CHAIN_STATS_EN
    ,
    output logic [15:0]             stat_xfers,
    output logic [15:0]             stat_ovf
`endif
);

    localparam int unsigned NumStages = NUM_OPS - 1;
    localparam int unsigned FullW     = OUT_W + OP_W;

    logic             adv;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_ovf_q;

    // A stalled, valid output freezes the whole chain.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------------
    // Multiply stages. Stage s multiplies the running product by op[s].
    // Operands not yet consumed travel with the transaction in rem_q, which
    // shrinks by one operand per stage, so every stage sees operands from the
    // same bundle as the product it receives.
    // ------------------------------------------------------------------------
    for (genvar s = 1; s <= NumStages; s++) begin : g_stage
        // Operands op[s] .. op[NUM_OPS-1] entering this stage.
        localparam int unsigned RemW = (NUM_OPS - s) * OP_W;

        logic [RemW-1:0]  rem_in;
        logic [OUT_W-1:0] prod_in;
        logic             vld_in;
        logic             ovf_in;
        logic             sat_in;
        logic [OP_W-1:0]  op_k;
        logic [FullW-1:0] full;

        logic             vld_d;
        logic [OUT_W-1:0] prod_d;
        logic             ovf_d;
        logic             sat_d;

        logic             vld_q;
        logic [OUT_W-1:0] prod_q;
        logic             ovf_q;
        logic             sat_q;

        if (s == 1) begin : g_src
            // op[0] acts as the incoming "product", zero-extended.
            assign rem_in  = in_ops[NUM_OPS*OP_W-1:OP_W];
            assign prod_in = OUT_W'(in_ops[OP_W-1:0]);
            assign vld_in  = in_valid;
            assign ovf_in  = 1'b0;
            assign sat_in  = in_sat;
        end else begin : g_src
            assign rem_in  = g_stage[s-1].g_carry.rem_q;
            assign prod_in = g_stage[s-1].prod_q;
            assign vld_in  = g_stage[s-1].vld_q;
            assign ovf_in  = g_stage[s-1].ovf_q;
            assign sat_in  = g_stage[s-1].sat_q;
        end

        assign op_k = rem_in[OP_W-1:0];
        // Full-width product so the bits above OUT_W can be inspected.
        assign full = {{OP_W{1'b0}}, prod_in} * {{OUT_W{1'b0}}, op_k};

        always_comb begin
            vld_d  = vld_in;
            prod_d = full[OUT_W-1:0];
            // Sticky: once any stage discards a nonzero bit, it stays flagged.
            ovf_d  = ovf_in | (|full[FullW-1:OUT_W]);
            sat_d  = sat_in;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q  <= 1'b0;
                prod_q <= '0;
                ovf_q  <= 1'b0;
                sat_q  <= 1'b0;
            end else if (adv) begin
                vld_q  <= vld_d;
                prod_q <= prod_d;
                ovf_q  <= ovf_d;
                sat_q  <= sat_d;
            end
        end

        if (s < NumStages) begin : g_carry
            logic [RemW-OP_W-1:0] rem_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rem_q <= '0;
                end else if (adv) begin
                    rem_q <= rem_in[RemW-1:OP_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register: applies the saturate selection.
    // ------------------------------------------------------------------------
    logic             last_vld;
    logic [OUT_W-1:0] last_prod;
    logic             last_ovf;
    logic             last_sat;
    logic [OUT_W-1:0] out_data_d;

    assign last_vld  = g_stage[NumStages].vld_q;
    assign last_prod = g_stage[NumStages].prod_q;
    assign last_ovf  = g_stage[NumStages].ovf_q;
    assign last_sat  = g_stage[NumStages].sat_q;

    always_comb begin
        out_data_d = last_prod;
        if (last_sat && last_ovf) begin
            out_data_d = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= last_vld;
            out_data_q  <= out_data_d;
            out_ovf_q   <= last_ovf;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

`ifdef MUL_CHAIN_STATS_EN
    // ------------------------------------------------------------------------
    // Retirement statistics, saturating at 0xFFFF.
    // ------------------------------------------------------------------------
    logic        retire;
    logic [15:0] stat_xfers_q;
    logic [15:0] stat_ovf_q;
    logic [15:0] stat_xfers_d;
    logic [15:0] stat_ovf_d;

    assign retire = out_valid_q && out_ready;

    always_comb begin
        stat_xfers_d = stat_xfers_q;
        stat_ovf_d   = stat_ovf_q;
        if (retire && (stat_xfers_q != 16'hFFFF)) begin
            stat_xfers_d = stat_xfers_q + 16'd1;
        end
        if (retire && out_ovf_q && (stat_ovf_q != 16'hFFFF)) begin
            stat_ovf_d = stat_ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_xfers_q <= '0;
            stat_ovf_q   <= '0;
        end else begin
            stat_xfers_q <= stat_xfers_d;
            stat_ovf_q   <= stat_ovf_d;
        end
    end

    assign stat_xfers = stat_xfers_q;
    assign stat_ovf   = stat_ovf_q;
`endif

endmodule

// File: tb/tb_mul_chain_pipe.sv
// ----------------------------------------------------------------------------
// Bench for mul_chain_pipe: a default 3-operand instance plus a 4-operand
// instance for the sticky-overflow case. Directed vectors with hand-computed
// expected results, then hand-written backpressure and mid-stream reset
// sequences.
// ----------------------------------------------------------------------------
module tb_mul_chain_pipe;

    logic clk;
    logic reset;

    // Default instance (NUM_OPS = 3)
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_ops;
    logic        in_sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;

    // Four-operand instance
    logic        d4_in_valid;
    logic        d4_in_ready;
    logic [63:0] d4_in_ops;
    logic        d4_in_sat;
    logic        d4_out_valid;
    logic        d4_out_ready;
    logic [31:0] d4_out_data;
    logic        d4_out_ovf;

`ifdef MUL_CHAIN_STATS_EN
    logic [15:0] stat_xfers;
    logic [15:0] stat_ovf;
    logic [15:0] d4_stat_xfers;
    logic [15:0] d4_stat_ovf;
`endif

    mul_chain_pipe u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
`ifdef MUL_CHAIN_STATS_EN
        ,
        .stat_xfers(stat_xfers),
        .stat_ovf  (stat_ovf)
`endif
    );

    mul_chain_pipe #(
        .NUM_OPS(4),
        .OP_W   (16),
        .OUT_W  (32)
    ) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (d4_in_valid),
        .in_ready  (d4_in_ready),
        .in_ops    (d4_in_ops),
        .in_sat    (d4_in_sat),
        .out_valid (d4_out_valid),
        .out_ready (d4_out_ready),
        .out_data  (d4_out_data),
        .out_ovf   (d4_out_ovf)
`ifdef MUL_CHAIN_STATS_EN
        ,
        .stat_xfers(d4_stat_xfers),
        .stat_ovf  (d4_stat_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        sat;
        logic [31:0] d;
        logic        o;
    } vec_t;

    vec_t tbl [8];

    // One isolated transaction on the default instance; checks latency too.
    task automatic apply3(input string name, input vec_t v);
        int lat;
        @(negedge clk);
        check({name, " in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_ops   = {v.c, v.b, v.a};
        in_sat   = v.sat;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, 3);
        check({name, " data"}, out_data, v.d);
        check({name, " ovf"}, out_ovf, v.o);
    endtask

    task automatic apply4(input string name, input logic [63:0] ops, input logic sat,
                          input logic [31:0] exp_d, input logic exp_o);
        int lat;
        @(negedge clk);
        d4_in_valid = 1'b1;
        d4_in_ops   = ops;
        d4_in_sat   = sat;
        @(negedge clk);
        d4_in_valid = 1'b0;
        lat = 1;
        while (!d4_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, 4);
        check({name, " data"}, d4_out_data, exp_d);
        check({name, " ovf"}, d4_out_ovf, exp_o);
    endtask

    initial begin
        int          idx;
        int          got;
        int          stall;
        int          seen;
        int          late;
        logic        held_v;
        logic [31:0] held_d;
        vec_t        v;

        n_vec = 0;
        n_err = 0;

        tbl[0] = '{a: 16'd3,     b: 16'd5,     c: 16'd7,     sat: 1'b0, d: 32'd105,      o: 1'b0};
        tbl[1] = '{a: 16'hFFFF,  b: 16'hFFFF,  c: 16'd2,     sat: 1'b0, d: 32'hFFFC0002, o: 1'b1};
        tbl[2] = '{a: 16'hFFFF,  b: 16'hFFFF,  c: 16'd2,     sat: 1'b1, d: 32'hFFFFFFFF, o: 1'b1};
        tbl[3] = '{a: 16'hFFFF,  b: 16'd1,     c: 16'd1,     sat: 1'b1, d: 32'h0000FFFF, o: 1'b0};
        tbl[4] = '{a: 16'hFFFF,  b: 16'hFFFF,  c: 16'd1,     sat: 1'b1, d: 32'hFFFE0001, o: 1'b0};
        tbl[5] = '{a: 16'h1000,  b: 16'h1000,  c: 16'h0100,  sat: 1'b0, d: 32'h00000000, o: 1'b1};
        tbl[6] = '{a: 16'h1000,  b: 16'h1000,  c: 16'h0100,  sat: 1'b1, d: 32'hFFFFFFFF, o: 1'b1};
        tbl[7] = '{a: 16'd0,     b: 16'hFFFF,  c: 16'hFFFF,  sat: 1'b1, d: 32'h00000000, o: 1'b0};

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_ops       = '0;
        in_sat       = 1'b0;
        out_ready    = 1'b1;
        d4_in_valid  = 1'b0;
        d4_in_ops    = '0;
        d4_in_sat    = 1'b0;
        d4_out_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_ovf", out_ovf, 0);
        check("reset in_ready", in_ready, 1);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            v = tbl[i];
            apply3($sformatf("vec%0d", i), v);
        end

        // Sticky overflow through a later multiply by zero
        apply4("sticky sat", {16'd0, 16'd4, 16'hFFFF, 16'hFFFF}, 1'b1, 32'hFFFFFFFF, 1'b1);
        apply4("sticky trunc", {16'd0, 16'd4, 16'hFFFF, 16'hFFFF}, 1'b0, 32'h00000000, 1'b1);

        // Backpressure: 8 back-to-back bundles, 5-cycle stall at first result
        idx    = 0;
        got    = 0;
        stall  = 0;
        seen   = 0;
        held_v = 1'b0;
        held_d = '0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            @(negedge clk);
            if (out_valid && seen == 0) begin
                seen  = 1;
                stall = 5;
            end
            out_ready = (stall == 0);
            if (idx < 8) begin
                in_valid = 1'b1;
                in_ops   = {16'd2, 16'(idx + 2), 16'(idx + 1)};
                in_sat   = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held_v) begin
                check("bp hold valid", out_valid, 1);
                check("bp hold data", out_data, held_d);
            end
            if (stall > 0) begin
                check("bp in_ready low", in_ready, 0);
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                check($sformatf("bp result%0d", got + 1), out_data,
                      64'(2 * (got + 1) * (got + 2)));
                got++;
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            if (stall > 0) stall--;
        end
        check("bp result count", got, 8);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;

`ifdef MUL_CHAIN_STATS_EN
        check("stats xfers before reset", stat_xfers, 16);
        check("stats ovf before reset", stat_ovf, 4);
`endif

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_ops   = {16'd3, 16'd2, 16'(i + 1)};
            in_sat   = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset out_data", out_data, 0);
`ifdef MUL_CHAIN_STATS_EN
        check("midreset stat_xfers", stat_xfers, 0);
        check("midreset stat_ovf", stat_ovf, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        late  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) late++;
        end
        check("no stale results", late, 0);

        v = '{a: 16'd2, b: 16'd3, c: 16'd4, sat: 1'b0, d: 32'd24, o: 1'b0};
        apply3("post reset", v);
`ifdef MUL_CHAIN_STATS_EN
        @(negedge clk);
        check("post reset stat_xfers", stat_xfers, 1);
        check("post reset stat_ovf", stat_ovf, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
